instruction_test_checker: RTL and testbench
===========================================

# instruction_test_checker

Self-checking end-of-test monitor for the instruction-test flow. It watches the core's PC to detect program halt, with a cycle-budget timeout as backstop. It then scans the core register file through a read port and compares every entry against a loadable table of expected values with per-register don't-care masks. It reports pass/fail, a mismatch count and the first failing register. It replaces fixed-delay, fully combinational checks with a parametrised, cycle-accurate sequential checker.

## Interface
- DATA_WIDTH, 32, register width
- NUM_REGS, 32, registers compared (indices 0..NUM_REGS-1)
- INDEX_BITS, 5, register index width; NUM_REGS <= 2**INDEX_BITS
- ADDRESS_BITS, 20, PC width
- TIMEOUT_CYCLES, 100, maximum RUN cycles before forced scan
- STABLE_CYCLES, 8, consecutive unchanged-PC cycles that declare halt
- clock  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  begin a test; honoured only in IDLE or DONE
- pc  in  ADDRESS_BITS  core fetch PC
- exp_wr_en  in  1  write an expected-table entry
- exp_wr_index  in  INDEX_BITS  entry written
- exp_wr_data  in  DATA_WIDTH  expected value
- exp_wr_mask  in  1  1 = don't-care, entry never mismatches
- reg_rd_index  out  INDEX_BITS  register-file read address
- reg_rd_data  in  DATA_WIDTH  register-file read data, combinational from reg_rd_index
- busy  out  1  state is RUN or SCAN
- done  out  1  state is DONE
- passed  out  1  valid when done: mismatch_count == 0 and no timeout
- timed_out  out  1  RUN ended by TIMEOUT_CYCLES, not halt
- mismatch_count  out  INDEX_BITS+1  number of mismatching entries
- first_fail_index  out  INDEX_BITS  lowest mismatching index
- first_fail_expected / first_fail_actual  out  DATA_WIDTH each  values at first mismatch

## Operation
- States: IDLE, RUN, SCAN, DONE. Reset enters IDLE.
- IDLE/DONE + start: clear cycle counter, stable counter, mismatch_count, first_fail_*, timed_out and passed; go to RUN. start in RUN/SCAN is ignored.
- RUN, per cycle: cycle_count increments.
  - If pc equals the previous-cycle pc, stable_count increments; otherwise it clears.
  - stable_count reaching STABLE_CYCLES goes to SCAN.
  - Otherwise, cycle_count reaching TIMEOUT_CYCLES sets timed_out and goes to SCAN.
  - If both happen in the same cycle, halt wins: timed_out stays 0.
- SCAN: scan_index runs 0..NUM_REGS-1, one per cycle, and drives reg_rd_index.
  - Mismatch when the mask bit is 0 and reg_rd_data != expected[scan_index]. A mismatch increments mismatch_count.
  - On the first mismatch only, latch first_fail_index, first_fail_expected and first_fail_actual.
  - After index NUM_REGS-1, go to DONE.
- DONE: results hold until reset or the next start. passed = (mismatch_count == 0) && !timed_out.
- Expected table: NUM_REGS x (DATA_WIDTH+1).
  - Written when exp_wr_en is set in IDLE or DONE. Writes in RUN/SCAN are dropped.
  - Writes with exp_wr_index >= NUM_REGS are dropped.
  - Reset clears all values to 0 and all masks to 0.
- reg_rd_index is 0 outside SCAN.

## Timing
- Reset values: busy=0, done=0, passed=0, timed_out=0, mismatch_count=0, first_fail_*=0, reg_rd_index=0.
- Start sampled at edge E, which enters RUN. The first pc comparison occurs at edge E+2; the pc sampled at E+1 is the reference.
- Halt detect: SCAN is entered at the edge where stable_count becomes STABLE_CYCLES.
- Timeout: SCAN is entered at the edge where cycle_count becomes TIMEOUT_CYCLES.
- SCAN lasts exactly NUM_REGS cycles. done rises at the edge after index NUM_REGS-1 is compared.
- Total latency from halt to done: NUM_REGS + 1 cycles.
- An exp_wr_en and start in the same DONE cycle: the write lands and the test starts.
- Reset asserted mid-RUN/SCAN: immediate return to IDLE, all results cleared, and the expected table cleared.

## Test plan
- Halt pass: load a1=0x00001000, a2=0x80000000, a3=0xfffff000 and others 0; reg file matches; pc halts at 0x40 after 20 cycles -> done at halt+8+33, passed=1, mismatch_count=0, timed_out=0.
- Multi-fail: same table with reg file x12=0x7fffffff and x20=0x5 -> mismatch_count=2, first_fail_index=12, first_fail_expected=0x80000000, first_fail_actual=0x7fffffff, passed=0.
- Mask: set exp_wr_mask=1 for x20 in the multi-fail case -> mismatch_count=1, first_fail_index=12.
- Timeout: pc increments every cycle -> timed_out=1 after 100 RUN cycles; scan still runs; passed=0 even with a matching reg file.
- Ignore rules: start pulsed mid-SCAN and exp_wr_en during RUN -> neither scan_index nor the table changes, and the result is identical to the undisturbed run.
- Reset mid-SCAN at index 7 -> outputs return to reset values at once; a new start after a reload yields a correct pass.

Source files
------------

// File: rtl/instruction_test_checker.sv
// instruction_test_checker: end-of-test monitor for the instruction-test flow.
// Waits for the core PC to settle (or a cycle budget to expire), then walks the
// register file through a read port and compares each entry against a loadable
// table of expected values with per-entry don't-care masks.
module instruction_test_checker #(
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_REGS       = 32,
  parameter int INDEX_BITS     = 5,
  parameter int ADDRESS_BITS   = 20,
  parameter int TIMEOUT_CYCLES = 100,
  parameter int STABLE_CYCLES  = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [ADDRESS_BITS-1:0] pc,
  input  logic                    exp_wr_en,
  input  logic [INDEX_BITS-1:0]   exp_wr_index,
  input  logic [DATA_WIDTH-1:0]   exp_wr_data,
  input  logic                    exp_wr_mask,
  output logic [INDEX_BITS-1:0]   reg_rd_index,
  input  logic [DATA_WIDTH-1:0]   reg_rd_data,
  output logic                    busy,
  output logic                    done,
  output logic                    passed,
  output logic                    timed_out,
  output logic [INDEX_BITS:0]     mismatch_count,
  output logic [INDEX_BITS-1:0]   first_fail_index,
  output logic [DATA_WIDTH-1:0]   first_fail_expected,
  output logic [DATA_WIDTH-1:0]   first_fail_actual
);

  localparam int CYC_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int STB_W = $clog2(STABLE_CYCLES + 1);
  localparam int CNT_W = INDEX_BITS + 1;

  localparam logic [CYC_W-1:0]      TIMEOUT_VAL  = CYC_W'(TIMEOUT_CYCLES);
  localparam logic [STB_W-1:0]      STABLE_VAL   = STB_W'(STABLE_CYCLES);
  localparam logic [INDEX_BITS-1:0] LAST_INDEX   = INDEX_BITS'(NUM_REGS - 1);
  localparam logic [CNT_W-1:0]      NUM_REGS_VAL = CNT_W'(NUM_REGS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_SCAN = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [CYC_W-1:0]        cycle_count_q, cycle_count_d;
  logic [STB_W-1:0]        stable_count_q, stable_count_d;
  logic [ADDRESS_BITS-1:0] prev_pc_q, prev_pc_d;
  logic                    ref_valid_q, ref_valid_d;
  logic [INDEX_BITS-1:0]   scan_index_q, scan_index_d;
  logic [CNT_W-1:0]        mismatch_count_q, mismatch_count_d;
  logic [INDEX_BITS-1:0]   ff_index_q, ff_index_d;
  logic [DATA_WIDTH-1:0]   ff_expected_q, ff_expected_d;
  logic [DATA_WIDTH-1:0]   ff_actual_q, ff_actual_d;
  logic                    timed_out_q, timed_out_d;
  logic                    passed_q, passed_d;
  logic [DATA_WIDTH-1:0]   exp_val_q  [NUM_REGS];
  logic [DATA_WIDTH-1:0]   exp_val_d  [NUM_REGS];
  logic                    exp_mask_q [NUM_REGS];
  logic                    exp_mask_d [NUM_REGS];

  logic                    table_wr_ok;
  logic                    mismatch;

  // Next-state, counters, scan comparison and expected-table write logic.
  always_comb begin
    state_d          = state_q;
    cycle_count_d    = cycle_count_q;
    stable_count_d   = stable_count_q;
    prev_pc_d        = prev_pc_q;
    ref_valid_d      = ref_valid_q;
    scan_index_d     = scan_index_q;
    mismatch_count_d = mismatch_count_q;
    ff_index_d       = ff_index_q;
    ff_expected_d    = ff_expected_q;
    ff_actual_d      = ff_actual_q;
    timed_out_d      = timed_out_q;
    passed_d         = passed_q;
    exp_val_d        = exp_val_q;
    exp_mask_d       = exp_mask_q;
    mismatch         = 1'b0;

    // Table writes only while no test is in flight, and only to real entries.
    table_wr_ok = exp_wr_en
                  && ((state_q == ST_IDLE) || (state_q == ST_DONE))
                  && ({1'b0, exp_wr_index} < NUM_REGS_VAL);
    if (table_wr_ok) begin
      exp_val_d[exp_wr_index]  = exp_wr_data;
      exp_mask_d[exp_wr_index] = exp_wr_mask;
    end else begin
      exp_val_d  = exp_val_q;
      exp_mask_d = exp_mask_q;
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d          = ST_RUN;
          cycle_count_d    = '0;
          stable_count_d   = '0;
          ref_valid_d      = 1'b0;
          scan_index_d     = '0;
          mismatch_count_d = '0;
          ff_index_d       = '0;
          ff_expected_d    = '0;
          ff_actual_d      = '0;
          timed_out_d      = 1'b0;
          passed_d         = 1'b0;
        end else begin
          state_d = state_q;
        end
      end

      ST_RUN: begin
        cycle_count_d = cycle_count_q + CYC_W'(1);
        prev_pc_d     = pc;
        ref_valid_d   = 1'b1;
        // The first RUN cycle only captures the reference PC.
        if (ref_valid_q && (pc == prev_pc_q)) begin
          stable_count_d = stable_count_q + STB_W'(1);
        end else begin
          stable_count_d = '0;
        end
        // Halt is checked first so it wins a same-cycle tie with the timeout.
        if (stable_count_d == STABLE_VAL) begin
          state_d      = ST_SCAN;
          scan_index_d = '0;
        end else if (cycle_count_d == TIMEOUT_VAL) begin
          state_d      = ST_SCAN;
          scan_index_d = '0;
          timed_out_d  = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end

      ST_SCAN: begin
        mismatch = !exp_mask_q[scan_index_q]
                   && (reg_rd_data != exp_val_q[scan_index_q]);
        if (mismatch) begin
          mismatch_count_d = mismatch_count_q + CNT_W'(1);
          if (mismatch_count_q == '0) begin
            ff_index_d    = scan_index_q;
            ff_expected_d = exp_val_q[scan_index_q];
            ff_actual_d   = reg_rd_data;
          end else begin
            ff_index_d = ff_index_q;
          end
        end else begin
          mismatch_count_d = mismatch_count_q;
        end
        if (scan_index_q == LAST_INDEX) begin
          state_d      = ST_DONE;
          scan_index_d = '0;
          passed_d     = (mismatch_count_d == '0) && !timed_out_q;
        end else begin
          scan_index_d = scan_index_q + INDEX_BITS'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counter, result and expected-table registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      cycle_count_q    <= '0;
      stable_count_q   <= '0;
      prev_pc_q        <= '0;
      ref_valid_q      <= 1'b0;
      scan_index_q     <= '0;
      mismatch_count_q <= '0;
      ff_index_q       <= '0;
      ff_expected_q    <= '0;
      ff_actual_q      <= '0;
      timed_out_q      <= 1'b0;
      passed_q         <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        exp_val_q[i]  <= '0;
        exp_mask_q[i] <= 1'b0;
      end
    end else begin
      state_q          <= state_d;
      cycle_count_q    <= cycle_count_d;
      stable_count_q   <= stable_count_d;
      prev_pc_q        <= prev_pc_d;
      ref_valid_q      <= ref_valid_d;
      scan_index_q     <= scan_index_d;
      mismatch_count_q <= mismatch_count_d;
      ff_index_q       <= ff_index_d;
      ff_expected_q    <= ff_expected_d;
      ff_actual_q      <= ff_actual_d;
      timed_out_q      <= timed_out_d;
      passed_q         <= passed_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        exp_val_q[i]  <= exp_val_d[i];
        exp_mask_q[i] <= exp_mask_d[i];
      end
    end
  end

  assign reg_rd_index        = scan_index_q;
  assign busy                = (state_q == ST_RUN) || (state_q == ST_SCAN);
  assign done                = (state_q == ST_DONE);
  assign passed              = passed_q;
  assign timed_out           = timed_out_q;
  assign mismatch_count      = mismatch_count_q;
  assign first_fail_index    = ff_index_q;
  assign first_fail_expected = ff_expected_q;
  assign first_fail_actual   = ff_actual_q;

endmodule

// File: tb/tb_instruction_test_checker.sv
// Self-checking bench for instruction_test_checker: directed scenarios with a
// behavioural model of the halt/timeout timeline and the scan result.
module tb_instruction_test_checker;

  localparam int DW  = 32;
  localparam int NR  = 32;
  localparam int IB  = 5;
  localparam int AB  = 20;
  localparam int TO  = 100;
  localparam int STB = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [AB-1:0] pc;
  logic          exp_wr_en;
  logic [IB-1:0] exp_wr_index;
  logic [DW-1:0] exp_wr_data;
  logic          exp_wr_mask;
  logic [IB-1:0] reg_rd_index;
  logic [DW-1:0] reg_rd_data;
  logic          busy, done, passed, timed_out;
  logic [IB:0]   mismatch_count;
  logic [IB-1:0] first_fail_index;
  logic [DW-1:0] first_fail_expected, first_fail_actual;

  logic [DW-1:0] rf    [NR];
  logic [DW-1:0] m_val [NR];
  logic          m_msk [NR];

  int  n_checks = 0;
  int  n_fail   = 0;
  int  edge_n   = 0;
  int  halt_g   = 0;
  int  m_start  = 0;
  int  m_scan   = 0;
  bit  m_to     = 1'b0;

  always #5 clock = ~clock;

  // Count rising edges so timeline expectations can be expressed in edges.
  always @(posedge clock) edge_n <= edge_n + 1;

  assign reg_rd_data = rf[reg_rd_index];

  instruction_test_checker dut (
    .clock               (clock),
    .reset               (reset),
    .start               (start),
    .pc                  (pc),
    .exp_wr_en           (exp_wr_en),
    .exp_wr_index        (exp_wr_index),
    .exp_wr_data         (exp_wr_data),
    .exp_wr_mask         (exp_wr_mask),
    .reg_rd_index        (reg_rd_index),
    .reg_rd_data         (reg_rd_data),
    .busy                (busy),
    .done                (done),
    .passed              (passed),
    .timed_out           (timed_out),
    .mismatch_count      (mismatch_count),
    .first_fail_index    (first_fail_index),
    .first_fail_expected (first_fail_expected),
    .first_fail_actual   (first_fail_actual)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // PC seen at edge start+j: walks by 4 until j reaches halt_g, then parks at 0x40.
  function automatic logic [AB-1:0] pc_of(input int j);
    if (j > halt_g) return 20'h00040;
    else return AB'(j * 4);
  endfunction

  // Scan entry (in edges after start) and timeout flag from the PC trace.
  task automatic predict();
    int st;
    st     = 0;
    m_scan = TO;
    m_to   = 1'b1;
    for (int j = 2; j <= TO; j++) begin
      if (pc_of(j) == pc_of(j - 1)) st++;
      else st = 0;
      if (st == STB) begin
        m_scan = j;
        m_to   = 1'b0;
        break;
      end
    end
  endtask

  // busy/done/reg_rd_index against the model timeline, rel edges after start.
  task automatic check_cycle(input int rel);
    logic          eb, ed;
    logic [IB-1:0] ei;
    if (rel < 0) return;
    eb = (rel < m_scan + NR);
    ed = !eb;
    ei = (rel >= m_scan && rel < m_scan + NR) ? IB'(rel - m_scan) : 5'd0;
    n_checks++;
    if (busy !== eb || done !== ed || reg_rd_index !== ei) begin
      n_fail++;
      $display("FAIL timeline rel=%0d: busy=%b done=%b idx=%0d expected busy=%b done=%b idx=%0d",
               rel, busy, done, reg_rd_index, eb, ed, ei);
    end
  endtask

  task automatic check_results(input string tag);
    int            mm;
    logic [IB-1:0] fi;
    logic [DW-1:0] fe, fa;
    mm = 0; fi = '0; fe = '0; fa = '0;
    for (int i = 0; i < NR; i++) begin
      if (!m_msk[i] && rf[i] != m_val[i]) begin
        if (mm == 0) begin
          fi = IB'(i); fe = m_val[i]; fa = rf[i];
        end
        mm++;
      end
    end
    chk({tag, "_passed"},    passed, (mm == 0) && !m_to);
    chk({tag, "_timed_out"}, timed_out, m_to);
    chk({tag, "_mm_count"},  mismatch_count, mm);
    chk({tag, "_ff_index"},  first_fail_index, fi);
    chk({tag, "_ff_exp"},    first_fail_expected, fe);
    chk({tag, "_ff_act"},    first_fail_actual, fa);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_busy"},   busy, 0);
    chk({tag, "_done"},   done, 0);
    chk({tag, "_passed"}, passed, 0);
    chk({tag, "_to"},     timed_out, 0);
    chk({tag, "_mm"},     mismatch_count, 0);
    chk({tag, "_ffi"},    first_fail_index, 0);
    chk({tag, "_ffe"},    first_fail_expected, 0);
    chk({tag, "_ffa"},    first_fail_actual, 0);
    chk({tag, "_rdidx"},  reg_rd_index, 0);
  endtask

  task automatic wr(input int idx, input logic [DW-1:0] d, input bit m);
    @(negedge clock);
    exp_wr_en = 1'b1; exp_wr_index = IB'(idx); exp_wr_data = d; exp_wr_mask = m;
    m_val[idx] = d; m_msk[idx] = m;
    @(negedge clock);
    exp_wr_en = 1'b0;
  endtask

  task automatic run_test(input string tag, input int h, input bit disturb, input bit rst7,
                          input int exp_lat, input bit ws_en, input int ws_idx,
                          input logic [DW-1:0] ws_data, input bit ws_mask);
    int rel;
    bit seen;
    @(negedge clock);
    halt_g = h;
    predict();
    m_start = edge_n + 1;
    start = 1'b1;
    pc = '0;
    if (ws_en) begin
      exp_wr_en = 1'b1; exp_wr_index = IB'(ws_idx); exp_wr_data = ws_data; exp_wr_mask = ws_mask;
      m_val[ws_idx] = ws_data; m_msk[ws_idx] = ws_mask;
    end
    seen = 1'b0;
    rel  = 0;
    for (int k = 0; k < 400 && !seen; k++) begin
      @(negedge clock);
      rel = edge_n - m_start;
      start = 1'b0;
      exp_wr_en = 1'b0;
      pc = pc_of(rel + 1);
      check_cycle(rel);
      if (rst7 && busy && reg_rd_index == 5'd7) begin
        reset = 1'b1;
        #1;
        check_reset_vals({tag, "_midscan_rst"});
        for (int i = 0; i < NR; i++) begin
          m_val[i] = '0; m_msk[i] = 1'b0;
        end
        @(negedge clock);
        reset = 1'b0;
        return;
      end
      if (disturb && rel == 5) begin
        exp_wr_en = 1'b1; exp_wr_index = 5'd12; exp_wr_data = 32'h7fffffff; exp_wr_mask = 1'b0;
      end
      if (disturb && rel == m_scan + 10) start = 1'b1;
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_done_wait: done not seen within 400 cycles", tag);
      return;
    end
    chk({tag, "_latency"}, rel, exp_lat);
    repeat (3) begin
      @(negedge clock);
      check_cycle(edge_n - m_start);
    end
    check_results(tag);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; pc = '0;
    exp_wr_en = 1'b0; exp_wr_index = '0; exp_wr_data = '0; exp_wr_mask = 1'b0;
    for (int i = 0; i < NR; i++) begin
      rf[i] = '0; m_val[i] = '0; m_msk[i] = 1'b0;
    end
    repeat (3) @(negedge clock);
    check_reset_vals("reset");
    reset = 1'b0;

    // Halt pass: done 20+8+33 = 61 edges after start.
    wr(11, 32'h00001000, 1'b0);
    wr(12, 32'h80000000, 1'b0);
    wr(13, 32'hfffff000, 1'b0);
    rf[11] = 32'h00001000; rf[12] = 32'h80000000; rf[13] = 32'hfffff000;
    run_test("halt_pass", 20, 1'b0, 1'b0, 61, 1'b0, 0, '0, 1'b0);
    chk("halt_pass_pin_passed", passed, 1);
    chk("halt_pass_pin_mm", mismatch_count, 0);

    // Two mismatches, first at x12.
    rf[12] = 32'h7fffffff; rf[20] = 32'h00000005;
    run_test("multi_fail", 20, 1'b0, 1'b0, 61, 1'b0, 0, '0, 1'b0);
    chk("multi_fail_pin_mm", mismatch_count, 2);
    chk("multi_fail_pin_ffi", first_fail_index, 12);
    chk("multi_fail_pin_ffe", first_fail_expected, 32'h80000000);
    chk("multi_fail_pin_ffa", first_fail_actual, 32'h7fffffff);
    chk("multi_fail_pin_passed", passed, 0);

    // Mask x20, written in the same DONE cycle as start.
    run_test("mask", 20, 1'b0, 1'b0, 61, 1'b1, 20, 32'h0, 1'b1);
    chk("mask_pin_mm", mismatch_count, 1);
    chk("mask_pin_ffi", first_fail_index, 12);

    // Timeout with a matching register file: done 100+32 edges after start.
    rf[12] = 32'h80000000; rf[20] = 32'h0;
    run_test("timeout", 100000, 1'b0, 1'b0, 132, 1'b0, 0, '0, 1'b0);
    chk("timeout_pin_to", timed_out, 1);
    chk("timeout_pin_passed", passed, 0);
    chk("timeout_pin_mm", mismatch_count, 0);

    // RUN-time write and SCAN-time start must both be ignored.
    rf[12] = 32'h7fffffff; rf[20] = 32'h00000005;
    run_test("ignore", 20, 1'b1, 1'b0, 61, 1'b0, 0, '0, 1'b0);
    chk("ignore_pin_mm", mismatch_count, 1);
    chk("ignore_pin_ffi", first_fail_index, 12);
    chk("ignore_pin_ffa", first_fail_actual, 32'h7fffffff);

    // Reset at scan index 7, then a run against the cleared table.
    run_test("rst7", 20, 1'b0, 1'b1, 0, 1'b0, 0, '0, 1'b0);
    run_test("cleared", 20, 1'b0, 1'b0, 61, 1'b0, 0, '0, 1'b0);
    chk("cleared_pin_mm", mismatch_count, 4);
    chk("cleared_pin_ffi", first_fail_index, 11);
    chk("cleared_pin_ffa", first_fail_actual, 32'h00001000);

    // Reload and pass.
    wr(11, 32'h00001000, 1'b0);
    wr(12, 32'h80000000, 1'b0);
    wr(13, 32'hfffff000, 1'b0);
    rf[12] = 32'h80000000; rf[20] = 32'h0;
    run_test("reload", 20, 1'b0, 1'b0, 61, 1'b0, 0, '0, 1'b0);
    chk("reload_pin_passed", passed, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
